// File: rtl/step_counter_pkg.sv
// Shared types and helpers for the step_counter3 button-driven 3-bit counter.
package step_counter_pkg;

  typedef logic [2:0] count_t;

  typedef enum logic {IDLE_REL, IDLE_PRS} db_state_e;

  // Clock cycles in a given number of milliseconds, never less than one.
  function automatic int unsigned cyc_of_ms(input int unsigned clk_hz, input int unsigned ms);
    int unsigned c;
    c = clk_hz / 1000 * ms;
    return (c == 0) ? 1 : c;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronises one raw active-low button and debounces it into a one-cycle press pulse.
module key_debounce
  import step_counter_pkg::*;
#(
  parameter int unsigned DB_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press_p
);

  localparam int unsigned CW = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;

  logic [1:0]    sync_q;
  logic          key_s;
  db_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  assign key_s   = sync_q[1];
  assign press_p = press_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      state_q <= IDLE_REL;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_n};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  // Counter only runs while the synchronised level disagrees with the debounced level.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (key_s != (state_q == IDLE_REL)) begin
      if (cnt_q == CW'(DB_CYC - 1)) begin
        unique case (state_q)
          IDLE_REL: begin
            state_d = IDLE_PRS;
            press_d = 1'b1;
          end
          IDLE_PRS: state_d = IDLE_REL;
        endcase
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/step_counter3.sv
// Debounced up/down modulo-8 counter feeding Q2..Q0 of the 7-segment decoder.
// Optional auto-step prescaler enabled by defining STEP_AUTO_EN.
module step_counter3
  import step_counter_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned AUTO_HZ     = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_up,
  input  logic key_dn,
  input  logic run,
  output logic Q0,
  output logic Q1,
  output logic Q2
);

  localparam int unsigned DB_CYC   = cyc_of_ms(CLK_HZ, DEBOUNCE_MS);
  localparam int unsigned AUTO_DIV = (AUTO_HZ == 0) ? 1 : AUTO_HZ;
  localparam int unsigned TICK_RAW = CLK_HZ / AUTO_DIV;
  localparam int unsigned TICK_CYC = (TICK_RAW == 0) ? 1 : TICK_RAW;

  logic   up_p, dn_p, tick;
  count_t count_q, count_d;

  key_debounce #(.DB_CYC(DB_CYC)) u_db_up (
    .clk    (clk),
    .rst_n  (rst_n),
    .key_n  (key_up),
    .press_p(up_p)
  );

  key_debounce #(.DB_CYC(DB_CYC)) u_db_dn (
    .clk    (clk),
    .rst_n  (rst_n),
    .key_n  (key_dn),
    .press_p(dn_p)
  );

`ifdef STEP_AUTO_EN
  localparam int unsigned PW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;

  logic [PW-1:0] presc_q;

  assign tick = run && (presc_q == PW'(TICK_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else if (!run || tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end
`else
  logic unused_cfg;

  assign tick       = 1'b0;
  assign unused_cfg = run ^ (TICK_CYC == 0);
`endif

  // Simultaneous up and down pulses cancel; a tick stacks with an up pulse.
  always_comb begin
    count_d = count_q + count_t'(up_p) - count_t'(dn_p) + count_t'(tick);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign Q0 = count_q[0];
  assign Q1 = count_q[1];
  assign Q2 = count_q[2];

endmodule

// File: tb/tb_step_counter3.sv
// Directed bench for step_counter3 with a scoreboard of expected Q2..Q0 values.
module tb_step_counter3;

  logic clk    = 1'b0;
  logic rst_n  = 1'b1;
  logic key_up = 1'b1;
  logic key_dn = 1'b1;
  logic run    = 1'b0;
  logic Q0, Q1, Q2;

  logic [2:0] exp_q[$];
  logic [2:0] model = 3'd0;
  int n_checks = 0;
  int n_errors = 0;

  step_counter3 #(
    .CLK_HZ     (1000),
    .DEBOUNCE_MS(4),
    .AUTO_HZ    (100)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .key_up(key_up),
    .key_dn(key_dn),
    .run   (run),
    .Q0    (Q0),
    .Q1    (Q1),
    .Q2    (Q2)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_q(input logic [2:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag);
    logic [2:0] obs, exp;
    obs = {Q2, Q1, Q0};
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $error("FAIL %s: observed %b but scoreboard empty", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        n_errors++;
        $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
    end
  endtask

  // Call just after an edge; that edge is edge 0 for the latency count.
  task automatic press(input bit up, input bit dn, input string tag);
    key_up = !up;
    key_dn = !dn;
    cyc(6);
    expect_q(model);
    check({tag, "_edge6"});
    model = model + 3'(up) - 3'(dn);
    cyc(1);
    expect_q(model);
    check({tag, "_edge7"});
    cyc(13);
    key_up = 1'b1;
    key_dn = 1'b1;
    cyc(12);
    expect_q(model);
    check({tag, "_held"});
  endtask

  task automatic do_reset(input string tag);
    #3;
    rst_n = 1'b0;
    #1;
    model = 3'd0;
    expect_q(model);
    check(tag);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1);
  endtask

  initial begin
    // 1. async reset mid-cycle
    #2;
    rst_n = 1'b0;
    #1;
    expect_q(3'd0);
    check("reset_async");
    cyc(3);
    expect_q(3'd0);
    check("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    cyc(5);
    expect_q(3'd0);
    check("reset_idle");

    // 2. single press, exact latency, hold gives one step
    press(1'b1, 1'b0, "up_first");

    // 3. bouncing then stable low: one step
    for (int i = 0; i < 5; i++) begin
      key_up = 1'b0;
      cyc(2);
      key_up = 1'b1;
      cyc(1);
    end
    key_up = 1'b0;
    cyc(20);
    key_up = 1'b1;
    cyc(12);
    model = model + 3'd1;
    expect_q(model);
    check("bounce_single_step");
    for (int i = 0; i < 5; i++) begin
      key_up = 1'b0;
      cyc(3);
      key_up = 1'b1;
      cyc(3);
    end
    cyc(10);
    expect_q(model);
    check("glitch_no_step");

    // async reset from a nonzero count
    do_reset("reset_nonzero");

    // 4. wrap-around both directions
    for (int i = 0; i < 7; i++) press(1'b1, 1'b0, "wrap_up");
    expect_q(3'b111);
    check("wrap_at_7");
    press(1'b1, 1'b0, "wrap_7_to_0");
    expect_q(3'b000);
    check("wrap_zero");
    press(1'b0, 1'b1, "wrap_0_to_7");
    expect_q(3'b111);
    check("wrap_seven");

    // 5. simultaneous presses cancel
    for (int i = 0; i < 4; i++) press(1'b0, 1'b1, "down");
    expect_q(3'b011);
    check("down_to_3");
    press(1'b1, 1'b1, "both_cancel");

    // 6. auto-step
    do_reset("reset_auto");
`ifdef STEP_AUTO_EN
    run = 1'b1;
    cyc(9);
    expect_q(model);
    check("auto_before_tick");
    cyc(1);
    model = model + 3'd1;
    expect_q(model);
    check("auto_tick1");
    cyc(10);
    model = model + 3'd1;
    expect_q(model);
    check("auto_tick2");
    run = 1'b0;
    cyc(10);
    expect_q(model);
    check("auto_frozen");
    for (int i = 0; i < 4; i++) press(1'b1, 1'b0, "to_six");
    expect_q(3'b110);
    check("at_six");
    run = 1'b1;
    cyc(3);
    key_up = 1'b0;
    cyc(6);
    expect_q(model);
    check("tick_up_before");
    cyc(1);
    run = 1'b0;
    model = model + 3'd2;
    expect_q(model);
    check("tick_plus_up");
    cyc(10);
    key_up = 1'b1;
    cyc(12);
    expect_q(model);
    check("tick_up_after");
    run = 1'b1;
    cyc(5);
    run = 1'b0;
    cyc(5);
    expect_q(model);
    check("run_off_frozen");
    run = 1'b1;
    cyc(9);
    expect_q(model);
    check("presc_restart_early");
    cyc(1);
    model = model + 3'd1;
    expect_q(model);
    check("presc_restart_tick");
    run = 1'b0;
`else
    run = 1'b1;
    cyc(30);
    run = 1'b0;
    expect_q(model);
    check("run_ignored");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
